// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-channel debounce FSM
// state encodings and the default confirmation interval.
package button_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } db_state_e;

    // 10 ms of stable samples at a 1 MHz system clock.
    localparam int DB_CYCLES_DEFAULT = 10000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, registered level and one-cycle press/release strobes.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_in,
    output logic       level_out,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [1:0] state_dbg
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             meta_q, sync_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // The synchronizer runs regardless of ena so the FSM sees a fresh level on resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            meta_q    <= btn_in;
            sync_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (ena) begin
            case (state_q)
                ST_LOW: begin
                    if (sync_q) begin
                        state_d = ST_CHK_HIGH;
                        cnt_d   = '0;
                    end
                end
                ST_CHK_HIGH: begin
                    if (!sync_q) begin
                        state_d = ST_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!sync_q) begin
                        state_d = ST_CHK_LOW;
                        cnt_d   = '0;
                    end
                end
                ST_CHK_LOW: begin
                    if (sync_q) begin
                        state_d = ST_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = ST_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_LOW;
            endcase
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign state_dbg     = state_q;

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent debounced button channels sharing one clock, reset and enable.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N_CH-1:0]   btn_in,
    output logic [N_CH-1:0]   level_out,
    output logic [N_CH-1:0]   press_pulse,
    output logic [N_CH-1:0]   release_pulse,
    output logic [2*N_CH-1:0] state_dbg
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .ena          (ena),
            .btn_in       (btn_in[g]),
            .level_out    (level_out[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .state_dbg    (state_dbg[2*g +: 2])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DB_CYCLES=4, N_CH=3: a per-cycle
// vector table plus hand-written reset, simultaneous-press and enable sequences.
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] btn_in;
    logic [2:0] level_out, press_pulse, release_pulse;
    logic [5:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] btn;
        logic       ena;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .N_CH     (3),
        .DB_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .btn_in       (btn_in),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int idx,
                            input logic [2:0] lvl, input logic [2:0] prs, input logic [2:0] rel);
        chk({name, ".level"},   idx, {3'b0, level_out},     {3'b0, lvl});
        chk({name, ".press"},   idx, {3'b0, press_pulse},   {3'b0, prs});
        chk({name, ".release"}, idx, {3'b0, release_pulse}, {3'b0, rel});
    endtask

    task automatic do_reset();
        btn_in = 3'b000;
        ena    = 1'b1;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Table index j is the rising edge the vector's inputs precede; outputs checked after it.
        for (int j = 1; j <= 70; j++) begin
            vec_t v;
            v.ena    = 1'b1;
            v.btn[0] = (j <= 20);
            v.btn[1] = (j >= 41 && j <= 43) || (j == 45) || (j == 46) || (j >= 48 && j <= 60);
            v.btn[2] = (j == 31);
            v.lvl    = {1'b0, (j >= 54 && j <= 66), (j >= 7 && j <= 26)};
            v.prs    = {1'b0, (j == 54), (j == 7)};
            v.rel    = {1'b0, (j == 67), (j == 27)};
            vecs.push_back(v);
        end

        rst_n  = 1'b1;
        ena    = 1'b1;
        btn_in = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        chk_outs("reset", 0, 3'b000, 3'b000, 3'b000);
        chk("reset.state", 0, state_dbg, 6'b0);
        tick();
        tick();
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            btn_in = vecs[k].btn;
            ena    = vecs[k].ena;
            tick();
            chk_outs("table", k + 1, vecs[k].lvl, vecs[k].prs, vecs[k].rel);
        end

        do_reset();
        btn_in = 3'b011;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("simul.press", e, {3'b0, press_pulse}, (e == 7) ? 6'b000011 : 6'b0);
            chk("simul.level", e, {3'b0, level_out},   (e >= 7) ? 6'b000011 : 6'b0);
        end

        do_reset();
        btn_in = 3'b010;
        repeat (10) tick();
        btn_in = 3'b011;
        repeat (4) tick();
        chk("pre_rst.level", 0, {3'b0, level_out}, 6'b000010);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 3'b000, 3'b000, 3'b000);
        chk("async_rst.state", 0, state_dbg, 6'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("post_rst.press", e, {3'b0, press_pulse}, (e == 7) ? 6'b000011 : 6'b0);
            chk("post_rst.level", e, {3'b0, level_out},   (e >= 7) ? 6'b000011 : 6'b0);
        end

        do_reset();
        btn_in = 3'b001;
        for (int e = 1; e <= 20; e++) begin
            ena = !(e >= 4 && e <= 10);
            tick();
            chk_outs("ena", e, (e >= 14) ? 3'b001 : 3'b000, (e == 14) ? 3'b001 : 3'b000, 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 3: number of independent button channels (ch0 start_stop, ch1 lap_time, ch2 clear).
REQ-002 Parameter DB_CYCLES, default 10000: stable-sample count that confirms a level change (10 ms at 1 MHz); legal range is DB_CYCLES >= 2.
REQ-003 Port clk, input, 1: single system clock (1 MHz); all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port ena, input, 1: high means conditioning active; low freezes debounce state.
REQ-006 Port btn_in, input, N_CH: raw asynchronous, bouncing button levels; 1 means pressed.
REQ-007 Port level_out, output, N_CH: debounced registered button level per channel.
REQ-008 Port press_pulse, output, N_CH: one-cycle strobe on each confirmed 0->1 change.
REQ-009 Port release_pulse, output, N_CH: one-cycle strobe on each confirmed 1->0 change.

Function
REQ-010 Each channel SHALL pass btn_in[i] through a 2-flop synchronizer; only the second flop (sync) feeds the channel FSM.
REQ-011 Each channel FSM SHALL have exactly 4 states: LOW, CHK_HIGH, HIGH, CHK_LOW.
REQ-012 In LOW with sync=1, the FSM SHALL go to CHK_HIGH and clear the counter to 0.
REQ-013 In CHK_HIGH with sync=0, the FSM SHALL return to LOW with no output change (bounce rejected).
REQ-014 In CHK_HIGH with sync=1, the FSM SHALL increment the counter; when the counter equals DB_CYCLES-1, it SHALL instead go to HIGH, set level_out[i]=1 and assert press_pulse[i] for exactly one cycle.
REQ-015 HIGH, CHK_LOW and release_pulse SHALL behave symmetrically to REQ-012..014 with the polarity inverted, ending with level_out[i]=0.
REQ-016 Latency: with btn_in[i] stable high before rising edge 1, press_pulse[i] SHALL be high after rising edge DB_CYCLES+3 and low after edge DB_CYCLES+4.
REQ-017 The counter SHALL be ceil(log2(DB_CYCLES)) bits wide and SHALL never wrap; it is cleared on every CHK state entry.
REQ-018 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle; a new pulse on a channel SHALL require at least DB_CYCLES+1 cycles since that channel's previous pulse.
REQ-019 Channels SHALL be fully independent; simultaneous confirmations on several channels SHALL produce pulses in the same cycle.
REQ-020 While ena=0: pulses SHALL be forced to 0; FSM state, counter and level_out SHALL hold; the synchronizers SHALL keep running.
REQ-021 When ena returns to 1, counting SHALL resume from the held counter value; no pulse suppressed during ena=0 SHALL be replayed.

Reset
REQ-022 rst_n=0 SHALL immediately clear synchronizers, counters, level_out, press_pulse and release_pulse to 0, and force every FSM to LOW.
REQ-023 A button held through reset deassertion SHALL produce a normal press_pulse, DB_CYCLES+3 edges after rst_n rises.
REQ-024 Reset asserted mid-CHK_HIGH or mid-CHK_LOW SHALL discard the partial count with no pulse.

Structure
REQ-025 The four state encodings and the DB_CYCLES default SHALL live in a shared package/include, button_pkg.
REQ-026 The per-channel logic (synchronizer, FSM, counter) SHALL be one sub-module, debounce_channel, instantiated N_CH times by a generate loop.
REQ-027 The top level SHALL contain no logic beyond the ena fan-out and the bus concatenation.

Verification (DB_CYCLES=4, N_CH=3)
REQ-028 ch0 raw high for 20 cycles, then low -> press_pulse[0]=1 only after edge 7 and level_out[0]=1; release_pulse[0]=1 for one cycle 7 edges after the fall; level_out[0]=0.
REQ-029 ch1 pattern high 3, low 1, high 2, low 1, then stable high -> exactly one press_pulse[1], 7 edges after the start of the final stable run.
REQ-030 ch2 single-cycle glitch high -> no pulses and level_out[2]=0 throughout.
REQ-031 ch0 and ch1 rise on the same cycle -> press_pulse[0] and press_pulse[1] are high in the same cycle; ch2 stays 0.
REQ-032 ch0 held high, rst_n low for 2 cycles during CHK_HIGH -> all outputs 0 asynchronously; press_pulse[0] occurs 7 edges after rst_n rises.
REQ-033 ena=0 from edge 4 to edge 10 while ch0 is held high -> no pulse in that window; press_pulse[0] appears after the remaining count completes once ena=1, and never twice.
